// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_if
// Description : Request/result bundle for the bit-serial subtractor.
//               The ovf signal exists only when SIGNED_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bw;
`ifdef SIGNED_OVF_EN
   logic             ovf;
`endif

   // Controller side: issues requests, observes results
   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bw
`ifdef SIGNED_OVF_EN
      , input ovf
`endif
   );

   // Subtractor side: accepts requests, produces results
   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bw
`ifdef SIGNED_OVF_EN
      , output ovf
`endif
   );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial WIDTH-bit subtractor computing a - b - bin, one
//               full-subtractor cell per cycle, LSB first. The result
//               {bw,diff} is the (WIDTH+1)-bit two's-complement difference.
//               Optional macro SIGNED_OVF_EN adds a signed overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   serial_subtractor_if.slave  bus
);

   // Counter must be at least one bit wide even for WIDTH=1
   localparam int               CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] pr;
   logic             br;
   logic [CW-1:0]    cnt;
`ifdef SIGNED_OVF_EN
   logic             a_msb;
   logic             b_msb;
`endif

   logic             d;
   logic             nbr;
   logic [WIDTH-1:0] pr_next;

   // Single full-subtractor cell operating on the current LSBs
   assign d   = ra[0] ^ rb[0] ^ br;
   assign nbr = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);

   // New difference bit enters at the MSB; after WIDTH shifts bit 0 is at the LSB
   assign pr_next = (pr >> 1) | (WIDTH'(d) << (WIDTH - 1));

   // Control FSM and datapath; busy/done are registered alongside state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         ra       <= '0;
         rb       <= '0;
         pr       <= '0;
         br       <= 1'b0;
         cnt      <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.diff <= '0;
         bus.bw   <= 1'b0;
`ifdef SIGNED_OVF_EN
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         bus.ovf  <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  ra       <= bus.a;
                  rb       <= bus.b;
                  br       <= bus.bin;
                  pr       <= '0;
                  cnt      <= '0;
`ifdef SIGNED_OVF_EN
                  a_msb    <= bus.a[WIDTH-1];
                  b_msb    <= bus.b[WIDTH-1];
`endif
                  bus.busy <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               ra  <= ra >> 1;
               rb  <= rb >> 1;
               pr  <= pr_next;
               br  <= nbr;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  // Results are published only here, so they hold through the next operation
                  bus.diff <= pr_next;
                  bus.bw   <= nbr;
`ifdef SIGNED_OVF_EN
                  // d is the MSB of the final difference on this edge
                  bus.ovf  <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing a - b - bin.
- One full-subtractor cell is used per cycle, with a registered borrow and operand shift registers, LSB first.
- Sits downstream of the single-bit full subtractor cell and reuses the same diff/borrow equations.
- Trades WIDTH cycles of latency for one-cell area. Intended as the multi-bit datapath stage fed by a controller issuing start pulses.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a subtraction; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  initial borrow-in; captured on accepted start.
- busy  output  1  high while in SHIFT state.
- done  output  1  one-cycle pulse: result valid and newly updated.
- diff  output  WIDTH  registered difference, held until the next result.
- bw  output  1  registered final borrow-out.
- ovf  output  1  signed overflow flag (only with SIGNED_OVF_EN).

Behaviour:
- One clock. Reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, busy=0, done=0, diff=0, bw=0, ovf=0.
  - Internal shift registers, borrow and bit counter are cleared.
  - Reset overrides start and aborts any in-flight operation. No done is produced for an aborted operation.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1, capture a, b and bin into regs ra, rb, br. Set counter=0 and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one bit per edge:
  - d = ra[0]^rb[0]^br.
  - nbr = (~ra[0]&rb[0]) | (~(ra[0]^rb[0])&br).
  - Shift ra and rb right by 1. Shift d into the MSB of the partial result register. br <= nbr. counter++.
  - On the edge that processes bit WIDTH-1:
    - diff <= final partial result; bw <= nbr.
    - Go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge goes to IDLE unconditionally.
- start is ignored in SHIFT and DONE. No queuing: a start must be re-presented in IDLE.
- Latency:
  - start sampled at edge k: busy=1 for the cycles after edges k .. k+WIDTH-1.
  - done=1 in the cycle after edge k+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles.
- Output stability:
  - diff and bw change only on entry to DONE.
  - During SHIFT they keep the previous result.
  - Operand inputs may change freely after the start edge.
- Arithmetic: {bw,diff} equals the (WIDTH+1)-bit two's-complement result of a - b - bin. bw=1 iff a < b+bin (unsigned).
- WIDTH=1: behaves as the single-cell full subtractor registered, with 1 shift cycle.
- busy and done are Moore outputs decoded from state and are never high together.

Optional Feature:
- Macro SIGNED_OVF_EN.
- Defined:
  - ovf port exists.
  - On entry to DONE, ovf <= (a_msb ^ b_msb) & (a_msb ^ diff_msb), using the captured operand MSBs.
  - ovf is held with diff and cleared by reset.
- Undefined:
  - ovf port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, start for 1 cycle -> busy 8 cycles, then done pulse; diff=0x02, bw=0.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bw=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bw=1.
- Start accepted with a=0x10, b=0x01; raise start again with a=0xFF, b=0x00 while busy -> request ignored; diff=0x0F; exactly one done pulse.
- Reset mid-SHIFT (cycle 4 of 8) -> next cycle IDLE, busy=0, diff=0, bw=0; no done pulse. A new start then yields a correct result.
- WIDTH=1, sweep all 8 {a,b,bin} combinations -> diff/bw match the full subtractor truth table, e.g. 0,1,1 -> diff=0, bw=1.
- SIGNED_OVF_EN, WIDTH=8:
  - 0x80-0x01 -> diff=0x7F, ovf=1.
  - 0x7F-0xFF -> diff=0x80, ovf=1.
  - 0x05-0x03 -> ovf=0.
